// File: rtl/clint_pkg.sv
// Shared constants and helpers for the core-local interruptor: register
// offsets, trap cause codes and the byte-lane store merge.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;
  localparam logic [63:0] CLINT_WINDOW_SIZE  = 64'h0000_0000_0001_0000;

  localparam logic [3:0] IRQ_MSI         = 4'd3;
  localparam logic [3:0] IRQ_MTI         = 4'd7;
  localparam logic [3:0] EXC_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] EXC_STORE_FAULT = 4'd7;

  // Replace only the byte lanes enabled in mask; other lanes keep old_v.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  mask);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: prescaler, mtime and mtimecmp with byte-masked stores, and
// the unsigned compare that produces the raw timer-pending level.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_cmp_i,
  input  logic        wr_time_i,
  input  logic [7:0]  wmask_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        mtip_o
);

  localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic             tick;

  assign tick = (tick_cnt_q == CNT_LAST);

  // A store to mtime overrides a coincident tick; the prescaler runs on.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    mtime_d    = mtime_q;
    if (wr_time_i)  mtime_d = merge_bytes(mtime_q, wdata_i, wmask_i);
    else if (tick)  mtime_d = mtime_q + 64'd1;
    mtimecmp_d = wr_cmp_i ? merge_bytes(mtimecmp_q, wdata_i, wmask_i) : mtimecmp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = mtimecmp_q;
  assign mtip_o     = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/clint.sv
// Core-local interruptor top: window decode, msip, read mux, interrupt
// priority towards the trap handler, and access-fault exceptions.
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_dmem,
  input  logic        is_LOAD,
  input  logic [7:0]  dmem_word_sel,
  input  logic [63:0] r_dmem_addr,
  input  logic [63:0] w_dmem_data,
  output logic        clint_sel,
  output logic [63:0] clint_data,
  output logic        mip_msip,
  output logic        mip_mtip,
  output logic        irq_en,
  output logic [3:0]  irq_code,
  output logic [63:0] irq_val,
  output logic        exc_en,
  output logic [3:0]  exc_code,
  output logic [63:0] exc_val
);

  logic [63:0] rel_addr, mtime, mtimecmp;
  logic [15:0] ofs;
  logic        aligned, hit_msip, hit_cmp, hit_time, legal, mtip;
  logic        msip_q, msip_d;
  logic        mip_msip_q, mip_mtip_q, irq_en_q;
  logic [3:0]  irq_code_q, irq_code_d;

  assign rel_addr  = r_dmem_addr - BASE_ADDR;
  assign clint_sel = (r_dmem_addr >= BASE_ADDR) && (rel_addr < CLINT_WINDOW_SIZE);
  assign ofs       = rel_addr[15:0];
  assign aligned   = (r_dmem_addr[2:0] == 3'b000);
  assign hit_msip  = clint_sel && aligned && (ofs == CLINT_MSIP_OFS);
  assign hit_cmp   = clint_sel && aligned && (ofs == CLINT_MTIMECMP_OFS);
  assign hit_time  = clint_sel && aligned && (ofs == CLINT_MTIME_OFS);
  assign legal     = hit_msip || hit_cmp || hit_time;

  assign exc_en   = clint_sel && (we_dmem || is_LOAD) && !legal;
  assign exc_code = !exc_en ? 4'd0 : (is_LOAD ? EXC_LOAD_FAULT : EXC_STORE_FAULT);
  assign exc_val  = exc_en ? r_dmem_addr : 64'd0;

  always_comb begin
    clint_data = 64'd0;
    if (hit_msip)      clint_data = {63'd0, msip_q};
    else if (hit_cmp)  clint_data = mtimecmp;
    else if (hit_time) clint_data = mtime;
  end

  clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_cmp_i   (we_dmem && hit_cmp),
    .wr_time_i  (we_dmem && hit_time),
    .wmask_i    (dmem_word_sel),
    .wdata_i    (w_dmem_data),
    .mtime_o    (mtime),
    .mtimecmp_o (mtimecmp),
    .mtip_o     (mtip)
  );

  // Software interrupt wins over the timer when both are pending.
  always_comb begin
    msip_d     = (we_dmem && hit_msip && dmem_word_sel[0]) ? w_dmem_data[0] : msip_q;
    irq_code_d = msip_q ? IRQ_MSI : (mtip ? IRQ_MTI : 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q     <= 1'b0;
      mip_msip_q <= 1'b0;
      mip_mtip_q <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_code_q <= 4'd0;
    end else begin
      msip_q     <= msip_d;
      mip_msip_q <= msip_q;
      mip_mtip_q <= mtip;
      irq_en_q   <= msip_q || mtip;
      irq_code_q <= irq_code_d;
    end
  end

  assign mip_msip = mip_msip_q;
  assign mip_mtip = mip_mtip_q;
  assign irq_en   = irq_en_q;
  assign irq_code = irq_code_q;
  assign irq_val  = 64'd0;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: one instance with TICK_DIV=1 and one with
// TICK_DIV=4 share the access bus; expectations go through a scoreboard queue.
module tb_clint;
  import clint_pkg::*;

  localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, we, ld;
  logic [7:0]  mask;
  logic [63:0] addr, wdata;

  logic        sel_1, msip_1, mtip_1, irq_en_1, exc_en_1;
  logic [3:0]  irq_code_1, exc_code_1;
  logic [63:0] rdata_1, irq_val_1, exc_val_1;
  logic        sel_4, msip_4, mtip_4, irq_en_4, exc_en_4;
  logic [3:0]  irq_code_4, exc_code_4;
  logic [63:0] rdata_4, irq_val_4, exc_val_4;

  always #5 clk = ~clk;

  clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .we_dmem(we), .is_LOAD(ld), .dmem_word_sel(mask),
    .r_dmem_addr(addr), .w_dmem_data(wdata), .clint_sel(sel_1), .clint_data(rdata_1),
    .mip_msip(msip_1), .mip_mtip(mtip_1), .irq_en(irq_en_1), .irq_code(irq_code_1),
    .irq_val(irq_val_1), .exc_en(exc_en_1), .exc_code(exc_code_1), .exc_val(exc_val_1)
  );

  clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .we_dmem(we), .is_LOAD(ld), .dmem_word_sel(mask),
    .r_dmem_addr(addr), .w_dmem_data(wdata), .clint_sel(sel_4), .clint_data(rdata_4),
    .mip_msip(msip_4), .mip_mtip(mtip_4), .irq_en(irq_en_4), .irq_code(irq_code_4),
    .irq_val(irq_val_4), .exc_en(exc_en_4), .exc_code(exc_code_4), .exc_val(exc_val_4)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input string tag, input logic [63:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_v(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h required a queued entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    we = 1'b0; ld = 1'b0; mask = 8'h00; addr = 64'd0; wdata = 64'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    addr = a; wdata = d; mask = m; we = 1'b1;
    step(1);
    idle();
  endtask

  task automatic rd1(input string tag, input logic [63:0] a, input logic [63:0] e);
    expect_v(tag, e);
    addr = a; ld = 1'b1;
    #1;
    check_v(rdata_1);
    idle();
  endtask

  task automatic rd4(input string tag, input logic [63:0] a, input logic [63:0] e);
    expect_v(tag, e);
    addr = a; ld = 1'b1;
    #1;
    check_v(rdata_4);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step(2);
    rst = 1'b0;

    // Reset state
    expect_v("rst_irq_en", 64'd0);   check_v(64'(irq_en_1));
    expect_v("rst_irq_code", 64'd0); check_v(64'(irq_code_1));
    expect_v("rst_mip_msip", 64'd0); check_v(64'(msip_1));
    expect_v("rst_mip_mtip", 64'd0); check_v(64'(mtip_1));
    rd1("rst_mtime", A_TIME, 64'd0);
    rd1("rst_mtimecmp", A_CMP, ONES);
    rd1("rst_msip", A_MSIP, 64'd0);

    // Free-running count
    step(10);
    rd1("mtime_10", A_TIME, 64'd10);
    expect_v("idle_irq_en", 64'd0); check_v(64'(irq_en_1));

    // Timer interrupt
    store(A_CMP, 64'd20, 8'hFF);
    step(9);
    rd1("mtime_20", A_TIME, 64'd20);
    expect_v("mti_not_yet", 64'd0); check_v(64'(irq_en_1));
    step(1);
    expect_v("mti_irq_en", 64'd1);   check_v(64'(irq_en_1));
    expect_v("mti_irq_code", 64'd7); check_v(64'(irq_code_1));
    expect_v("mti_irq_val", 64'd0);  check_v(irq_val_1);
    expect_v("mti_mip_mtip", 64'd1); check_v(64'(mtip_1));

    // Software interrupt has priority
    store(A_MSIP, 64'd1, 8'hFF);
    expect_v("msi_lat_code", 64'd7); check_v(64'(irq_code_1));
    step(1);
    expect_v("msi_code", 64'd3);     check_v(64'(irq_code_1));
    expect_v("msi_mip_msip", 64'd1); check_v(64'(msip_1));
    store(A_MSIP, 64'd0, 8'hFF);
    step(1);
    expect_v("msi_clr_code", 64'd7); check_v(64'(irq_code_1));

    // Raising mtimecmp clears MTI one cycle later
    store(A_CMP, 64'd1000, 8'hFF);
    expect_v("mti_clr_lat", 64'd1);  check_v(64'(irq_en_1));
    step(1);
    expect_v("mti_clr_en", 64'd0);   check_v(64'(irq_en_1));
    expect_v("mti_clr_code", 64'd0); check_v(64'(irq_code_1));

    // Read during a store returns the pre-edge value
    addr = A_CMP; wdata = ONES; mask = 8'hFF; we = 1'b1;
    #1;
    expect_v("pre_edge_read", 64'd1000); check_v(rdata_1);
    step(1);
    idle();
    store(A_CMP, 64'h11, 8'h01);
    rd1("byte_mask", A_CMP, 64'hFFFF_FFFF_FFFF_FF11);

    // Misaligned load fault
    addr = BASE + 64'h4004; ld = 1'b1;
    #1;
    expect_v("ldf_exc_en", 64'd1);               check_v(64'(exc_en_1));
    expect_v("ldf_exc_code", 64'd5);             check_v(64'(exc_code_1));
    expect_v("ldf_exc_val", BASE + 64'h4004);    check_v(exc_val_1);
    expect_v("ldf_data", 64'd0);                 check_v(rdata_1);
    step(1);
    idle();

    // Misaligned and unmapped store faults leave registers untouched
    addr = BASE + 64'h4004; wdata = 64'd0; mask = 8'hFF; we = 1'b1;
    #1;
    expect_v("stf_mis_code", 64'd7); check_v(64'(exc_code_1));
    step(1);
    idle();
    rd1("stf_mis_cmp", A_CMP, 64'hFFFF_FFFF_FFFF_FF11);
    addr = BASE + 64'h100; wdata = ONES; mask = 8'hFF; we = 1'b1;
    #1;
    expect_v("stf_exc_en", 64'd1);            check_v(64'(exc_en_1));
    expect_v("stf_exc_code", 64'd7);          check_v(64'(exc_code_1));
    expect_v("stf_exc_val", BASE + 64'h100);  check_v(exc_val_1);
    step(1);
    idle();
    rd1("stf_msip", A_MSIP, 64'd0);

    // Outside the window
    addr = BASE + 64'h1_0000; ld = 1'b1;
    #1;
    expect_v("out_hi_sel", 64'd0);  check_v(64'(sel_1));
    expect_v("out_hi_exc", 64'd0);  check_v(64'(exc_en_1));
    expect_v("out_hi_data", 64'd0); check_v(rdata_1);
    addr = BASE - 64'd8;
    #1;
    expect_v("out_lo_sel", 64'd0);  check_v(64'(sel_1));
    expect_v("out_lo_exc", 64'd0);  check_v(64'(exc_en_1));
    idle();

    // Prescaled timer
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    rd4("div4_mtime_0", A_TIME, 64'd0);
    step(1);
    rd4("div4_mtime_1", A_TIME, 64'd1);
    store(A_TIME, ONES, 8'hFF);
    rd4("div4_wr_max", A_TIME, ONES);
    step(2);
    rd4("div4_hold_max", A_TIME, ONES);
    expect_v("div4_mtip_eq", 64'd1);  check_v(64'(mtip_4));
    expect_v("div4_code_eq", 64'd7);  check_v(64'(irq_code_4));
    step(1);
    rd4("div4_wrap", A_TIME, 64'd0);
    step(3);
    store(A_TIME, 64'd100, 8'hFF);
    rd4("div4_store_wins", A_TIME, 64'd100);
    step(4);
    rd4("div4_after_win", A_TIME, 64'd101);

    // Reset with a store in flight
    store(A_MSIP, 64'd1, 8'hFF);
    step(1);
    expect_v("pre_rst_irq", 64'd1); check_v(64'(irq_en_4));
    rst = 1'b1; addr = A_CMP; wdata = 64'd0; mask = 8'hFF; we = 1'b1;
    step(1);
    rst = 1'b0;
    idle();
    expect_v("mid_rst_irq_en", 64'd0);   check_v(64'(irq_en_4));
    expect_v("mid_rst_irq_code", 64'd0); check_v(64'(irq_code_4));
    rd4("mid_rst_cmp", A_CMP, ONES);
    rd4("mid_rst_msip", A_MSIP, 64'd0);
    rd4("mid_rst_mtime", A_TIME, 64'd0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint.md
# clint

Core-local interruptor: memory-mapped machine timer and software-interrupt source that drives the interrupt inputs of the trap handler, the producer end of the `irq_en/irq_code/irq_val` interface currently tied off in the CPU top. It sits beside `dmem` on the data-access path: it decodes the same store/load strobes and byte mask, and serves loads and stores to `msip`, `mtimecmp` and `mtime`. It also raises an access exception in the same `exc_en/exc_code/exc_val` style as the other exception sources.

## Interface
- `BASE_ADDR`, 64'h0000_0000_0200_0000: base of the 64 KiB register window.
- `TICK_DIV`, 1: clock cycles per `mtime` increment; must be ≥1.
- `clk` input 1: clock. All state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `we_dmem` input 1: store strobe for the current instruction.
- `is_LOAD` input 1: load strobe for the current instruction.
- `dmem_word_sel` input 8: byte-lane enables; bit i selects byte i of `w_dmem_data`.
- `r_dmem_addr` input 64: access address, which is the ALU result.
- `w_dmem_data` input 64: store data.
- `clint_sel` output 1: combinational; high when `r_dmem_addr` lies in the window.
- `clint_data` output 64: combinational read data, 0 when not selected.
- `mip_msip`, `mip_mtip` output 1 each: registered pending bits, fed to the CSR mip image.
- `irq_en` output 1: registered interrupt request.
- `irq_code` output 4: 3 is MSI, 7 is MTI.
- `irq_val` output 64: always 0.
- `exc_en` output 1: combinational access fault.
- `exc_code` output 4: 5 for a load access fault, 7 for a store access fault.
- `exc_val` output 64: the faulting address.

## Operation
- Register map, as offsets from `BASE_ADDR`:
  - 0x0000 is `msip`. Only bit 0 is implemented; other bits read as 0.
  - 0x4000 is `mtimecmp`, 64 bits.
  - 0xBFF8 is `mtime`, 64 bits.
- Access is legal only for `r_dmem_addr[2:0]==0`, and only at the three offsets above.
- Any other selected access with `we_dmem|is_LOAD` raises `exc_en`. The register is not modified and `clint_data` is 0.
- Stores update only the byte lanes enabled in `dmem_word_sel`. Unselected bytes are unchanged.
- Prescaler `tick_cnt` counts 0..`TICK_DIV`-1. `mtime` increments by 1 when `tick_cnt==TICK_DIV-1`, then `tick_cnt` returns to 0.
- `mtime` wraps from 2^64-1 to 0.
- A store to `mtime` on a tick edge takes the store value; the increment is lost.
- The store does not reset `tick_cnt`.
- `mip_mtip` is set when `mtime >= mtimecmp`, as an unsigned compare of the current register values.
- `mip_msip` follows `msip[0]`.
- `irq_en` is `mip_msip | mip_mtip`. When both are pending, `irq_code=3` (MSI wins); otherwise the code is that of the pending source.
- `irq_code` is 0 when idle.
- Pending is level-sensitive. There is no acknowledge; software clears it by writing `msip=0` or by raising `mtimecmp`.
- Enable gating by mie/mstatus.MIE is the trap handler's job, not this block's.

## Timing
- Reset values:
  - `mtime`=0, `tick_cnt`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0.
  - `mip_msip`, `mip_mtip`, `irq_en`=0; `irq_code`=0.
- Reads are combinational in the same cycle, matching the single-cycle datapath. A read returns the pre-edge value even if a store to the same register lands on that edge.
- Register writes take effect at the rising edge that ends the access cycle.
- Interrupt latency is one cycle:
  - The compare is evaluated on register values during cycle N and captured into `mip_*` and `irq_en` at edge N+1.
  - Example: a store of `mtimecmp` at edge E gives `irq_en` high after edge E+1.
- When `mtime` crosses `mtimecmp` by incrementing at edge E, `mip_mtip` rises at edge E+1.
- When `rst` is asserted mid-operation, all state returns to its reset value at that edge, whatever store is in flight. `irq_en` is low in the following cycle.
- `exc_*` is purely combinational from the inputs. The trap handler samples it in the same cycle.

## Structure
- Shared package `clint_pkg` holds:
  - offset constants `CLINT_MSIP_OFS`, `CLINT_MTIMECMP_OFS`, `CLINT_MTIME_OFS`;
  - cause constants `IRQ_MSI=4'd3`, `IRQ_MTI=4'd7`, `EXC_LOAD_FAULT=4'd5`, `EXC_STORE_FAULT=4'd7`;
  - the window size.
- Natural sub-module `clint_timer`: the prescaler, `mtime`, `mtimecmp`, their byte-masked writes, and the compare that produces `mtip`.
- The top module keeps the address decode, `msip`, the read mux, the interrupt priority and the exceptions.

## Test plan
- Reset with `TICK_DIV=1`, then run 10 cycles idle → a load of `mtime` reads 10; `irq_en`=0; `mtimecmp` reads all-ones.
- Store `mtimecmp=20` with mask 8'hFF → `irq_en` rises the cycle after `mtime` reaches 20, with `irq_code`=7 and `irq_val`=0. Store `mtimecmp=1000` → `irq_en` falls one cycle later.
- Store `msip=1` while MTI is pending → `irq_code`=3. Store `msip=0` → `irq_code` returns to 7.
- With `TICK_DIV=4`: `mtime` increments every 4th cycle. A store of `mtime=2^64-1` wraps to 0 on the next tick. A store coinciding with a tick edge wins.
- Byte-masked store of 64'h11 with mask 8'h01 to `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF → reads 64'hFFFF_FFFF_FFFF_FF11.
- Accesses with no register change in either case:
  - Load at `BASE_ADDR+0x4004` → `exc_en`=1, `exc_code`=5, `exc_val`=`BASE_ADDR+0x4004`.
  - Store at `BASE_ADDR+0x100` → `exc_code`=7.
  - Access outside the window → `clint_sel`=0, `exc_en`=0.
